// File: rtl/serial_tx.sv
// serial_tx: byte-wide to serial line transmitter.
//
// Accepted bytes queue in a 2-entry FIFO and are sent one frame at a time
// through an 8-bit shift register. Each frame is 11 one-cycle bits:
// start(0), data[7:0] MSB first, odd parity (~^data), stop(1).
// STOP_GAP extra idle-high cycles (0-15) follow every stop bit.
//
// State table
//   IDLE   | line idle high, waiting for a queued byte
//   START  | start bit (0)
//   DATA   | 8 data bits, MSB first, bit_cnt counts 0..7 and wraps
//   PARITY | odd parity of the byte as loaded
//   STOP   | stop bit (1)
//   GAP    | STOP_GAP extra high cycles, gap_cnt counts down to 0
//
// Ports
//   clk      : sole clock, rising edge
//   reset    : synchronous active-high reset
//   tx_data  : byte to send, taken when tx_valid && tx_ready
//   tx_valid : producer offers tx_data
//   tx_ready : FIFO has room (count < 2)
//   out      : registered serial line, idle high
//   busy     : frame in flight or FIFO non-empty
module serial_tx #(
  parameter int unsigned STOP_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } state_t;

  // GAP runs gap_cnt from STOP_GAP-1 down to 0, i.e. STOP_GAP cycles.
  localparam logic [3:0] GAP_LOAD = (STOP_GAP > 0) ? 4'(STOP_GAP - 1) : 4'd0;
  localparam logic       HAS_GAP  = (STOP_GAP > 0);

  state_t      state, next_state;
  logic [7:0]  fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic [2:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic        push, pop;
  logic        fifo_nonempty;
  logic [7:0]  head;

  assign tx_ready      = (count != 2'd2);
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (count != 2'd0);
  assign head          = fifo_mem[rd_ptr];
  assign busy          = (state != IDLE) || fifo_nonempty;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START:  next_state = DATA;
      DATA:   if (bit_cnt == 3'd7) next_state = PARITY;
      PARITY: next_state = STOP;
      STOP: begin
        if (HAS_GAP) begin
          next_state = GAP;
        end else if (fifo_nonempty) begin
          pop        = 1'b1;
          next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out        <= 1'b1;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      bit_cnt    <= 3'd0;
      gap_cnt    <= 4'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
    end else begin
      state <= next_state;

      // Line value reflects the state being left, so out trails state by one edge.
      case (state)
        START:   out <= 1'b0;
        DATA:    out <= shift_reg[7];
        PARITY:  out <= parity_bit;
        default: out <= 1'b1;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= tx_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // Parity is latched with the byte so later tx_data changes cannot affect it.
      if (pop) begin
        shift_reg  <= head;
        parity_bit <= ~^head;
      end else if (state == DATA) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end

      if (state == DATA) bit_cnt <= bit_cnt + 3'd1;

      if (state == STOP)     gap_cnt <= GAP_LOAD;
      else if (state == GAP) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule
